// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter slice:
// FSM state encoding, default widths and the timeout counter width.
package alu_ctrl_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] WAKE  = 2'b01;
    localparam logic [1:0] ISSUE = 2'b10;
    localparam logic [1:0] WAIT  = 2'b11;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_A_WIDTH   = 8;
    localparam int DEF_B_WIDTH   = 8;
    localparam int DEF_OUT_WIDTH = 16;
    localparam int DEF_FUN_WIDTH = 4;
    localparam int DEF_TIMEOUT   = 4;

    localparam int TO_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (request vector), ptr (search start) ->
//        grant (one-hot), idx (grant index), any (some request set).
module rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int  j;
        logic found;
        grant = '0;
        idx   = '0;
        any   = |req;
        found = 1'b0;
        j     = 0;
        // Walk from ptr upward, wrapping, and take the first request.
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                grant = NUM_REQ'(1) << j;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered-output ALU among NUM_REQ requesters.
// Ports: CLK/RST (async active-low); REQ_* requester side with
//        REQ_ACK pulse; ALU_* operand/enable/clock-gate and result
//        inputs; RSP_DATA/RSP_ERR/RSP_VALID response to the winner.
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int B_WIDTH   = DEF_B_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int FUN_WIDTH = DEF_FUN_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    input  logic [NUM_REQ*A_WIDTH-1:0]     REQ_A,
    input  logic [NUM_REQ*B_WIDTH-1:0]     REQ_B,
    input  logic [NUM_REQ*FUN_WIDTH-1:0]   REQ_FUN,
    output logic [NUM_REQ-1:0]             REQ_ACK,
    output logic [A_WIDTH-1:0]             ALU_A,
    output logic [B_WIDTH-1:0]             ALU_B,
    output logic [FUN_WIDTH-1:0]           ALU_FUN,
    output logic                           ALU_EN,
    output logic                           ALU_CLK_EN,
    input  logic [OUT_WIDTH-1:0]           ALU_OUT,
    input  logic                           ALU_OUT_VALID,
    output logic [OUT_WIDTH-1:0]           RSP_DATA,
    output logic                           RSP_ERR,
    output logic [NUM_REQ-1:0]             RSP_VALID
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gidx;
    logic [TO_W-1:0]    cnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] rsp_hot;
    logic               to_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (REQ_VALID),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign ptr_nxt = (arb_idx == IDX_W'(NUM_REQ - 1)) ?
                     '0 : arb_idx + IDX_W'(1);
    assign rsp_hot = NUM_REQ'(1) << gidx;
    // Last permitted WAIT cycle without a result.
    assign to_hit  = (cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            ptr        <= '0;
            gidx       <= '0;
            cnt        <= '0;
            REQ_ACK    <= '0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_FUN    <= '0;
            ALU_EN     <= 1'b0;
            ALU_CLK_EN <= 1'b0;
            RSP_DATA   <= '0;
            RSP_ERR    <= 1'b0;
            RSP_VALID  <= '0;
        end else begin
            REQ_ACK   <= '0;
            ALU_EN    <= 1'b0;
            RSP_VALID <= '0;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        state      <= WAKE;
                        REQ_ACK    <= arb_grant;
                        gidx       <= arb_idx;
                        ptr        <= ptr_nxt;
                        ALU_CLK_EN <= 1'b1;
                        ALU_A   <= REQ_A[int'(arb_idx)*A_WIDTH +: A_WIDTH];
                        ALU_B   <= REQ_B[int'(arb_idx)*B_WIDTH +: B_WIDTH];
                        ALU_FUN <= REQ_FUN[int'(arb_idx)*FUN_WIDTH +: FUN_WIDTH];
                    end
                end
                WAKE: begin
                    state  <= ISSUE;
                    ALU_EN <= 1'b1;
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (ALU_OUT_VALID) begin
                        state      <= IDLE;
                        ALU_CLK_EN <= 1'b0;
                        cnt        <= '0;
                        RSP_DATA   <= ALU_OUT;
                        RSP_ERR    <= 1'b0;
                        RSP_VALID  <= rsp_hot;
                    end else if (to_hit) begin
                        state      <= IDLE;
                        ALU_CLK_EN <= 1'b0;
                        cnt        <= '0;
                        RSP_DATA   <= '0;
                        RSP_ERR    <= 1'b1;
                        RSP_VALID  <= rsp_hot;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
